// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address fields (16-frame layout) and
// the two-state cache fill FSM encoding.
package cpu_types_pkg;

    localparam int ICACHE_NFRAMES = 16;
    localparam int ICACHE_IDXW    = 4;
    localparam int ICACHE_TAGW    = 26;

    typedef struct packed {
        logic [ICACHE_TAGW-1:0] tag;
        logic [ICACHE_IDXW-1:0] idx;
        logic [1:0]             bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_frames.sv
// Direct-mapped one-word frame store: combinational read, single write port.
// Only valid bits are reset; tag/data contents are don't-care until filled.
module icache_frames #(
    parameter  int NFRAMES = 16,
    parameter  int TAGW    = 26,
    localparam int IDXW    = $clog2(NFRAMES)
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [IDXW-1:0] rd_idx,
    output logic            rd_vld,
    output logic [TAGW-1:0] rd_tag,
    output logic [31:0]     rd_dat,
    input  logic            wr_en,
    input  logic [IDXW-1:0] wr_idx,
    input  logic [TAGW-1:0] wr_tag,
    input  logic [31:0]     wr_dat
);

    logic [NFRAMES-1:0] valid_q;
    logic [TAGW-1:0]    tag_q  [NFRAMES];
    logic [31:0]        data_q [NFRAMES];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_dat;
        end
    end

    assign rd_vld = valid_q[rd_idx];
    assign rd_tag = tag_q[rd_idx];
    assign rd_dat = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache: zero-latency hit, blocking single-word fill.
// Optional ICACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module icache
    import cpu_types_pkg::*;
#(
    parameter int NFRAMES = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int IDXW = $clog2(NFRAMES);
    localparam int TAGW = 30 - IDXW;

    icache_state_t state_q, state_d;
    logic [29:0]   miss_q, miss_d;

    logic            rd_vld;
    logic [TAGW-1:0] rd_tag;
    logic [31:0]     rd_dat;
    logic            fill;
    logic            lookup_hit;
    logic            unused_bytoff;

    assign unused_bytoff = ^imemaddr[1:0];

    icache_frames #(
        .NFRAMES (NFRAMES),
        .TAGW    (TAGW)
    ) u_frames (
        .CLK    (CLK),
        .RST    (RST),
        .rd_idx (imemaddr[IDXW+1:2]),
        .rd_vld (rd_vld),
        .rd_tag (rd_tag),
        .rd_dat (rd_dat),
        .wr_en  (fill),
        .wr_idx (miss_q[IDXW-1:0]),
        .wr_tag (miss_q[29:IDXW]),
        .wr_dat (iload)
    );

    assign lookup_hit = imemREN && rd_vld && (rd_tag == imemaddr[31:IDXW+2]);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    // Lookups only happen in IDLE; the fill cycle never reports a hit.
    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        fill     = 1'b0;
        case (state_q)
            IDLE: begin
                if (lookup_hit) begin
                    ihit     = 1'b1;
                    imemload = rd_dat;
                end else if (imemREN) begin
                    miss_d  = imemaddr[31:2];
                    state_d = FETCH;
                end
            end
            FETCH: begin
                iREN  = 1'b1;
                iaddr = {miss_q, 2'b00};
                if (!iwait) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (ihit && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if ((state_q == IDLE) && (state_d == FETCH) && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed vector table, hand-built mid-fetch corner cases,
// then random accesses scored against a word-address frame model.
module tb_icache;

    localparam int NF = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: each frame remembers the full word address it holds.
    bit          m_valid [NF];
    logic [29:0] m_word  [NF];
    logic [31:0] m_data  [NF];

    always #5 CLK = ~CLK;

    icache #(.NFRAMES(NF)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        int          waits;
        logic [31:0] ld;
        bit          hit;
        logic [31:0] data;
    } vec_t;

    vec_t tbl [9];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        #2;
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] wa);
        return ({2'b00, wa} * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // One request from IDLE. On a miss, waits busy cycles then one fill
    // cycle, then the same address is re-presented and must hit.
    task automatic access(input string nm, input logic [31:0] a, input int waits,
                          input logic [31:0] ld, input bit exp_hit,
                          input logic [31:0] exp_data, input bit junk);
        int          idx;
        int          ren_cycles;
        logic [29:0] wa;
        wa  = a[31:2];
        idx = int'(wa) % NF;
        imemREN  = 1'b1;
        imemaddr = a;
        iwait    = 1'b1;
        #1;
        if (exp_hit) begin
            chk({nm, ".ihit"}, {31'd0, ihit}, 32'd1);
            chk({nm, ".data"}, imemload, exp_data);
            chk({nm, ".iREN"}, {31'd0, iREN}, 32'd0);
        end else begin
            chk({nm, ".miss_ihit"}, {31'd0, ihit}, 32'd0);
            chk({nm, ".miss_load"}, imemload, 32'd0);
            ren_cycles = 0;
            for (int w = 0; w <= waits; w++) begin
                next_cycle();
                if (w < waits) begin
                    iwait = 1'b1;
                    iload = $urandom;
                end else begin
                    iwait = 1'b0;
                    iload = ld;
                end
                if (junk && ($urandom_range(0, 1) == 1)) begin
                    imemaddr = $urandom;
                    imemREN  = 1'($urandom_range(0, 1));
                end
                #1;
                if (iREN) ren_cycles++;
                chk({nm, ".iaddr"}, iaddr, {wa, 2'b00});
                chk({nm, ".fetch_ihit"}, {31'd0, ihit}, 32'd0);
            end
            chk({nm, ".iREN_cycles"}, ren_cycles, waits + 1);
            m_valid[idx] = 1'b1;
            m_word[idx]  = wa;
            m_data[idx]  = ld;
            next_cycle();
            imemREN  = 1'b1;
            imemaddr = a;
            iwait    = 1'b1;
            #1;
            chk({nm, ".after_ihit"}, {31'd0, ihit}, 32'd1);
            chk({nm, ".after_data"}, imemload, ld);
            chk({nm, ".after_iREN"}, {31'd0, iREN}, 32'd0);
        end
        next_cycle();
    endtask

    initial begin
        logic [31:0] a, upper;
        logic [29:0] wa;
        int          idx;

        tbl[0] = '{"cold40",  32'h00000040, 3, 32'h8C220004, 1'b0, 32'h0};
        tbl[1] = '{"hit42",   32'h00000042, 0, 32'h0,        1'b1, 32'h8C220004};
        tbl[2] = '{"fill80",  32'h00000080, 1, 32'h11111111, 1'b0, 32'h0};
        tbl[3] = '{"conf40",  32'h00000040, 0, 32'h8C220004, 1'b0, 32'h0};
        tbl[4] = '{"top",     32'hFFFFFFFC, 2, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[5] = '{"top_hit", 32'hFFFFFFFD, 0, 32'h0,        1'b1, 32'hDEADBEEF};
        tbl[6] = '{"idx0",    32'h00000000, 0, 32'h12345678, 1'b0, 32'h0};
        tbl[7] = '{"idx15",   32'h0000003C, 1, 32'hCAFEF00D, 1'b0, 32'h0};
        tbl[8] = '{"idx15h",  32'h0000003E, 0, 32'h0,        1'b1, 32'hCAFEF00D};

        for (int i = 0; i < NF; i++) m_valid[i] = 1'b0;

        RST = 1'b1; imemREN = 1'b0; imemaddr = '0; iwait = 1'b1; iload = '0;
        #1;
        chk("rst.ihit", {31'd0, ihit}, 32'd0);
        chk("rst.imemload", imemload, 32'd0);
        chk("rst.iREN", {31'd0, iREN}, 32'd0);
        chk("rst.iaddr", iaddr, 32'd0);
        next_cycle();
        RST = 1'b0;
        imemREN = 1'b0; imemaddr = 32'h40;
        #1;
        chk("idle_noreq.ihit", {31'd0, ihit}, 32'd0);
        chk("idle_noreq.iREN", {31'd0, iREN}, 32'd0);
        next_cycle();
        #1;
        chk("idle_noreq.stay", {31'd0, iREN}, 32'd0);
        next_cycle();

        for (int i = 0; i < 9; i++) begin
            access(tbl[i].name, tbl[i].addr, tbl[i].waits, tbl[i].ld,
                   tbl[i].hit, tbl[i].data, 1'b0);
`ifdef ICACHE_STATS_EN
            if (i == 1) begin
                chk("stats.miss", miss_count, 32'd1);
                chk("stats.hit", hit_count, 32'd2);
            end
`endif
        end

        // Address changes while the fill for 0x100 is outstanding.
        imemREN = 1'b1; imemaddr = 32'h100; iwait = 1'b1;
        #1;
        chk("chg.miss", {31'd0, ihit}, 32'd0);
        for (int w = 0; w < 3; w++) begin
            next_cycle();
            imemaddr = 32'h104;
            imemREN  = (w != 1);
            iwait    = (w < 2);
            iload    = 32'hA5A5A5A5;
            #1;
            chk("chg.iaddr", iaddr, 32'h100);
            chk("chg.iREN", {31'd0, iREN}, 32'd1);
        end
        m_valid[0] = 1'b1; m_word[0] = 30'h40; m_data[0] = 32'hA5A5A5A5;
        next_cycle();
        access("chg104", 32'h104, 1, 32'h0BADF00D, 1'b0, 32'h0, 1'b0);
        access("chg100", 32'h100, 0, 32'h0, 1'b1, 32'hA5A5A5A5, 1'b0);

        // Reset asserted in the middle of a fill.
        imemREN = 1'b1; imemaddr = 32'h200; iwait = 1'b1;
        #1;
        chk("rstf.miss", {31'd0, ihit}, 32'd0);
        next_cycle();
        #1;
        chk("rstf.fetching", {31'd0, iREN}, 32'd1);
        RST = 1'b1; iwait = 1'b0; iload = 32'hBAD0BAD0;
        #1;
        chk("rstf.iREN", {31'd0, iREN}, 32'd0);
        chk("rstf.iaddr", iaddr, 32'd0);
        chk("rstf.ihit", {31'd0, ihit}, 32'd0);
        next_cycle();
        RST = 1'b0; iwait = 1'b1;
        for (int i = 0; i < NF; i++) m_valid[i] = 1'b0;
        access("rstf100", 32'h100, 1, 32'h77665544, 1'b0, 32'h0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 2))
                0:       upper = 32'h00000000;
                1:       upper = 32'h00001000;
                default: upper = 32'hFFFFFF00;
            endcase
            a   = upper | (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
            wa  = a[31:2];
            idx = int'(wa) % NF;
            access("rand", a, $urandom_range(0, 3), mem_word(wa),
                   m_valid[idx] && (m_word[idx] == wa), m_data[idx], 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 Parameter: NFRAMES, 16, number of direct-mapped one-word frames (power of two, 2..64).
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 imemREN  in  1  datapath instruction read request.
REQ-005 imemaddr  in  32  datapath byte address; bits[1:0] ignored.
REQ-006 ihit  out  1  imemload valid this cycle.
REQ-007 imemload  out  32  instruction word; 0 when ihit low.
REQ-008 iREN  out  1  memory read request.
REQ-009 iaddr  out  32  memory word address, bits[1:0]=0.
REQ-010 iwait  in  1  memory busy; iload valid in the cycle iwait is low while iREN high.
REQ-011 iload  in  32  memory read data.

Function
REQ-012 Address split: byte offset [1:0], index [log2(NFRAMES)+1:2], tag = remaining upper bits.
REQ-013 Hit: imemREN high, frame[index] valid, stored tag equals tag -> ihit=1, imemload=frame data, same cycle, zero latency.
REQ-014 FSM states IDLE and FETCH only; reset state IDLE.
REQ-015 IDLE: imemREN high and no hit -> latch miss address, go FETCH next edge; iREN=0 in IDLE.
REQ-016 FETCH: iREN=1, iaddr=latched miss address with [1:0]=0; ihit=0 unless REQ-017 applies.
REQ-017 FETCH with iwait=0: write iload, tag, valid=1 into frame of latched address, return IDLE; ihit=0 this cycle; hit seen next cycle.
REQ-018 FETCH with iwait=1: remain FETCH, latched address held, no frame write.
REQ-019 imemaddr change or imemREN drop during FETCH: fill completes for latched address; no abort; new address evaluated in IDLE.
REQ-020 imemREN low in IDLE: ihit=0, imemload=0, no state change.
REQ-021 Conflict fill to an occupied index overwrites tag and data unconditionally (no victim state).
REQ-022 Index 0 and index NFRAMES-1 behave identically; no wrap special-casing; address 0xFFFFFFFC valid.

Reset
REQ-023 RST high: state IDLE, all valid bits 0, ihit=0, imemload=0, iREN=0, iaddr=0, counters 0; in effect immediately, not waiting for CLK.
REQ-024 RST asserted during FETCH aborts the fill; no frame written; first request after release misses.
REQ-025 Frame data/tag arrays need not be reset; only valid bits.

Configuration
REQ-026 Macro ICACHE_STATS_EN defined: extra outputs hit_count 32 and miss_count 32; hit_count +1 each cycle ihit=1; miss_count +1 on each IDLE->FETCH transition; both saturate at 0xFFFFFFFF.
REQ-027 ICACHE_STATS_EN undefined: ports and counters absent; all other behaviour identical.

Structure
REQ-028 cpu_types_pkg gains icachef_t packed struct (tag, idx, bytoff) for NFRAMES=16 and typedef icache_state_t enum {IDLE, FETCH}.
REQ-029 Storage in sub-module icache_frames: valid/tag/data arrays, one combinational read port, one write port, async-reset valid bits.
REQ-030 icache holds FSM, miss-address register, hit compare, optional counters.

Verification
REQ-031 Cold miss: RST pulse, imemREN=1, imemaddr=0x40, iwait=1 for 3 cycles then 0 with iload=0x8C220004 -> iREN high 4 cycles, iaddr=0x40, ihit=1 with imemload=0x8C220004 the cycle after.
REQ-032 Repeat hit: after REQ-031, imemaddr=0x42 -> ihit=1 same cycle, imemload=0x8C220004, iREN=0.
REQ-033 Conflict: fill 0x40 then 0x80 (same index, NFRAMES=16) with iload=0x11111111 -> 0x40 subsequently misses and refetches.
REQ-034 Address change mid-fetch: miss on 0x100, switch to 0x104 while iwait=1 -> iaddr stays 0x100; after fill, 0x104 misses and fetches.
REQ-035 Reset mid-fetch: RST during FETCH -> iREN=0 immediately; after release 0x100 misses again.
REQ-036 ICACHE_STATS_EN: run REQ-031..REQ-032 -> miss_count=1, hit_count=2.
